// File: rtl/mcp3_ram512x025_fifo_ctl.sv
// First-word-fall-through FIFO controller sequencing an external 512x25 simple-dual-port RAM.
// The RAM holds committed entries; a 2-entry skid buffer at the head hides the 1-cycle read latency.
module mcp3_ram512x025_fifo_ctl #(
  parameter int DEPTH        = 512,
  parameter int AFULL_THRESH = 508
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_push,
  input  logic [24:0] i_push_data,
  output logic        o_full,
  output logic        o_almost_full,
  input  logic        i_pop,
  output logic        o_out_valid,
  output logic [24:0] o_out_data,
  output logic [9:0]  o_count,
  output logic        o_overflow,
  output logic        o_underflow,
  output logic        o_ram_wren,
  output logic [8:0]  o_ram_wrad,
  output logic [24:0] o_ram_data,
  output logic        o_ram_rden,
  output logic [8:0]  o_ram_rdad,
  input  logic [24:0] i_ram_q
);

  localparam logic [8:0] PTR_LAST    = 9'(DEPTH - 1);
  localparam logic [9:0] DEPTH_CNT   = 10'(DEPTH);
  localparam logic [9:0] AFULL_CNT   = 10'(AFULL_THRESH);
  localparam logic       AFULL_RESET = (AFULL_THRESH == 0);

  logic [8:0]  r_wr_ptr;
  logic [8:0]  r_rd_ptr;
  logic [9:0]  r_ram_cnt;
  logic [9:0]  r_count;
  logic [1:0]  r_skid_occ;
  logic [24:0] r_skid0;
  logic [24:0] r_skid1;
  logic        r_fetch_pending;
  logic        r_full;
  logic        r_almost_full;
  logic        r_overflow;
  logic        r_underflow;

  logic        w_push_fire;
  logic        w_pop_fire;
  logic        w_rden;
  logic [2:0]  w_head_demand;
  logic [9:0]  w_ram_cnt_nxt;
  logic [9:0]  w_count_nxt;
  logic [8:0]  w_wr_ptr_nxt;
  logic [8:0]  w_rd_ptr_nxt;
  logic [1:0]  w_occ_after_pop;
  logic [1:0]  w_skid_occ_nxt;
  logic [24:0] w_skid0_nxt;
  logic [24:0] w_skid1_nxt;

  always_comb begin
    w_push_fire   = i_push & ~r_full & ~i_reset;
    w_pop_fire    = i_pop & (r_skid_occ != 2'd0);
    // Only committed entries are read, so a read can never target the address being written.
    w_head_demand = {1'b0, r_skid_occ} + {2'b00, r_fetch_pending};
    w_rden        = (r_ram_cnt != 10'd0) & ~i_reset &
                    (w_head_demand < (3'd2 + {2'b00, w_pop_fire}));
    w_ram_cnt_nxt = r_ram_cnt + {9'd0, w_push_fire} - {9'd0, w_rden};

    w_wr_ptr_nxt = r_wr_ptr;
    if (w_push_fire) begin
      w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? 9'd0 : r_wr_ptr + 9'd1;
    end
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_rden) begin
      w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? 9'd0 : r_rd_ptr + 9'd1;
    end
  end

  always_comb begin
    w_skid0_nxt     = r_skid0;
    w_skid1_nxt     = r_skid1;
    w_occ_after_pop = r_skid_occ - {1'b0, w_pop_fire};
    if (w_pop_fire && (r_skid_occ == 2'd2)) begin
      w_skid0_nxt = r_skid1;
    end
    // Returning read data lands behind whatever survives this cycle's pop.
    if (r_fetch_pending) begin
      if (w_occ_after_pop == 2'd0) begin
        w_skid0_nxt = i_ram_q;
      end else begin
        w_skid1_nxt = i_ram_q;
      end
    end
    w_skid_occ_nxt = w_occ_after_pop + {1'b0, r_fetch_pending};
    w_count_nxt    = w_ram_cnt_nxt + {8'd0, w_skid_occ_nxt} + {9'd0, w_rden};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr        <= 9'd0;
      r_rd_ptr        <= 9'd0;
      r_ram_cnt       <= 10'd0;
      r_count         <= 10'd0;
      r_skid_occ      <= 2'd0;
      r_skid0         <= 25'd0;
      r_skid1         <= 25'd0;
      r_fetch_pending <= 1'b0;
      r_full          <= 1'b0;
      r_almost_full   <= AFULL_RESET;
      r_overflow      <= 1'b0;
      r_underflow     <= 1'b0;
    end else begin
      r_wr_ptr        <= w_wr_ptr_nxt;
      r_rd_ptr        <= w_rd_ptr_nxt;
      r_ram_cnt       <= w_ram_cnt_nxt;
      r_count         <= w_count_nxt;
      r_skid_occ      <= w_skid_occ_nxt;
      r_skid0         <= w_skid0_nxt;
      r_skid1         <= w_skid1_nxt;
      r_fetch_pending <= w_rden;
      r_full          <= (w_count_nxt == DEPTH_CNT);
      r_almost_full   <= (w_count_nxt >= AFULL_CNT);
      if (i_push && r_full) begin
        r_overflow <= 1'b1;
      end
      if (i_pop && (r_skid_occ == 2'd0)) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign o_full        = r_full;
  assign o_almost_full = r_almost_full;
  assign o_out_valid   = (r_skid_occ != 2'd0);
  assign o_out_data    = r_skid0;
  assign o_count       = r_count;
  assign o_overflow    = r_overflow;
  assign o_underflow   = r_underflow;
  assign o_ram_wren    = w_push_fire;
  assign o_ram_wrad    = r_wr_ptr;
  assign o_ram_data    = i_push_data;
  assign o_ram_rden    = w_rden;
  assign o_ram_rdad    = r_rd_ptr;

endmodule
